// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter byte port
// between NUM_REQ byte streams, with an optional burst cap and stall timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int MAX_BURST     = 0,
    parameter int STALL_TIMEOUT = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy
);

    localparam int PTR_W   = $clog2(NUM_REQ);
    localparam int BURST_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam int STALL_W = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    localparam logic [PTR_W:0]     NUM_REQ_W   = (PTR_W + 1)'(NUM_REQ);
    localparam logic [PTR_W-1:0]   LAST_IDX    = PTR_W'(NUM_REQ - 1);
    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(STALL_TIMEOUT);

    logic [0:0]         state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic [BURST_W-1:0] burst_cnt;
    logic [STALL_W-1:0] stall_cnt;
    logic               buf_valid;
    logic [7:0]         buf_data;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    logic [PTR_W:0]     cand;

    logic               owner_valid;
    logic               owner_last;
    logic [7:0]         owner_data;
    logic               can_accept;
    logic               owner_hs;
    logic [BURST_W-1:0] burst_next;
    logic [STALL_W-1:0] stall_next;
    logic               burst_rel;
    logic               stall_rel;
    logic               release_grant;

    // Round-robin pick: first valid requester scanning upward from ptr, wrapping.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (PTR_W + 1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!win_found && req_valid[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
        if (win_found) begin
            win_onehot[win_idx] = 1'b1;
        end
    end

    assign owner_valid = req_valid[owner];
    assign owner_last  = req_last[owner];
    assign owner_data  = req_data[{owner, 3'b000} +: 8];

    // The buffer can take a byte when empty or when it drains this same cycle.
    assign can_accept = !buf_valid || tx_ready;
    assign req_ready  = grant & {NUM_REQ{can_accept}};
    assign owner_hs   = (state == ST_OWN) && owner_valid && can_accept;

    assign burst_next = burst_cnt + 1'b1;
    assign stall_next = stall_cnt + 1'b1;
    assign burst_rel  = (MAX_BURST != 0) && owner_hs && (burst_next == BURST_LIMIT);
    assign stall_rel  = (STALL_TIMEOUT != 0) && (state == ST_OWN) && !owner_valid &&
                        (stall_next == STALL_LIMIT);
    assign release_grant = (owner_hs && owner_last) || burst_rel || stall_rel;

    assign tx_valid = buf_valid;
    assign tx_data  = buf_data;
    assign busy     = (|grant) || buf_valid;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            grant     <= '0;
            owner     <= '0;
            ptr       <= '0;
            burst_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        state <= ST_OWN;
                        grant <= win_onehot;
                        owner <= win_idx;
                    end
                end
                ST_OWN: begin
                    if (release_grant) begin
                        state     <= ST_IDLE;
                        grant     <= '0;
                        ptr       <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
                        burst_cnt <= '0;
                        stall_cnt <= '0;
                    end else begin
                        if ((MAX_BURST != 0) && owner_hs) begin
                            burst_cnt <= burst_next;
                        end
                        if (owner_valid) begin
                            stall_cnt <= '0;
                        end else if (stall_cnt != '1) begin
                            stall_cnt <= stall_next;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    // Output byte buffer; a byte already buffered still drains after a release.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            buf_valid <= 1'b0;
            buf_data  <= 8'h00;
        end else if (owner_hs) begin
            buf_valid <= 1'b1;
            buf_data  <= owner_data;
        end else if (buf_valid && tx_ready) begin
            buf_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: one instance with default parameters,
// one with MAX_BURST=2 and STALL_TIMEOUT=8; the idle instance is held in reset.
module tb_uart_tx_arbiter;

    localparam int NR = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n_a;
    logic              reset_n_b;
    logic              sel;
    logic [8*NR-1:0]   req_data;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_last;
    logic              tx_ready;

    logic [NR-1:0]     a_req_ready, b_req_ready, a_grant, b_grant;
    logic [7:0]        a_tx_data, b_tx_data;
    logic              a_tx_valid, b_tx_valid, a_busy, b_busy;

    logic [NR-1:0]     act_req_ready, act_grant;
    logic [7:0]        act_tx_data;
    logic              act_tx_valid, act_busy, act_reset_n;

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(0), .STALL_TIMEOUT(0)) dut_a (
        .clk(clk), .reset_n(reset_n_a),
        .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
        .req_ready(a_req_ready), .tx_data(a_tx_data), .tx_valid(a_tx_valid),
        .tx_ready(tx_ready), .grant(a_grant), .busy(a_busy)
    );

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(2), .STALL_TIMEOUT(8)) dut_b (
        .clk(clk), .reset_n(reset_n_b),
        .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
        .req_ready(b_req_ready), .tx_data(b_tx_data), .tx_valid(b_tx_valid),
        .tx_ready(tx_ready), .grant(b_grant), .busy(b_busy)
    );

    assign act_req_ready = sel ? b_req_ready : a_req_ready;
    assign act_grant     = sel ? b_grant     : a_grant;
    assign act_tx_data   = sel ? b_tx_data   : a_tx_data;
    assign act_tx_valid  = sel ? b_tx_valid  : a_tx_valid;
    assign act_busy      = sel ? b_busy      : a_busy;
    assign act_reset_n   = sel ? reset_n_b   : reset_n_a;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q [$];
    logic [8:0] src_q [NR][$];

    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] exp_byte;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic drive_reqs();
        logic [8:0] head;
        for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() > 0) begin
                head = src_q[i][0];
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = head[7:0];
                req_last[i]        = head[8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic src_push(input int r, input logic [7:0] d, input logic last);
        src_q[r].push_back({last, d});
    endtask

    task automatic push_byte(input int r, input logic [7:0] d, input logic last);
        src_push(r, d, last);
        exp_q.push_back(d);
    endtask

    // One clock: requester handshakes are sampled mid-cycle, consumed after the edge.
    task automatic applyStimulus(input int n);
        logic [NR-1:0] hs;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            hs = req_valid & act_req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (hs[i]) void'(src_q[i].pop_front());
            end
            drive_reqs();
            #1;
        end
    endtask

    task automatic wait_idle(input string name);
        int budget = 300;
        bit done = 1'b0;
        while (budget > 0 && !done) begin
            done = (exp_q.size() == 0) && !act_busy;
            for (int i = 0; i < NR; i++) begin
                if (src_q[i].size() != 0) done = 1'b0;
            end
            if (!done) begin
                applyStimulus(1);
                budget--;
            end
        end
        checkOutput(name, 32'(done), 32'd1);
    endtask

    // Monitor: pops the scoreboard on each transmitter handshake and checks
    // that tx_data holds while the transmitter stalls.
    initial begin
        forever begin
            @(negedge clk);
            if (prev_hold && act_reset_n) begin
                checkOutput("tx_hold", {act_tx_valid, act_tx_data}, {1'b1, prev_data});
            end
            if (act_tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL tx_unexpected: got %0h expected no byte", act_tx_data);
                end else begin
                    exp_byte = exp_q.pop_front();
                    checkOutput("tx_data", act_tx_data, exp_byte);
                end
            end
            prev_hold = act_reset_n && act_tx_valid && !tx_ready;
            prev_data = act_tx_data;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] burst_exp [8];
        sel       = 1'b0;
        reset_n_a = 1'b0;
        reset_n_b = 1'b0;
        tx_ready  = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        @(posedge clk);
        #1;
        applyStimulus(2);

        $display("[TB] reset values");
        checkOutput("rst_grant", a_grant, 0);
        checkOutput("rst_req_ready", a_req_ready, 0);
        checkOutput("rst_tx_valid", a_tx_valid, 0);
        checkOutput("rst_tx_data", a_tx_data, 0);
        checkOutput("rst_busy", a_busy, 0);

        $display("[TB] round-robin fairness");
        reset_n_a = 1'b1;
        tx_ready  = 1'b1;
        push_byte(0, 8'h10, 1'b1);
        push_byte(2, 8'h30, 1'b1);
        drive_reqs();
        checkOutput("rr_idle_grant", act_grant, 4'b0000);
        applyStimulus(1);
        checkOutput("rr_grant0", act_grant, 4'b0001);
        checkOutput("rr_ready0", act_req_ready, 4'b0001);
        applyStimulus(1);
        checkOutput("rr_bubble", act_grant, 4'b0000);
        checkOutput("rr_tx_valid", act_tx_valid, 1);
        checkOutput("rr_tx_data0", act_tx_data, 8'h10);
        applyStimulus(1);
        checkOutput("rr_grant2", act_grant, 4'b0100);
        applyStimulus(1);
        checkOutput("rr_tx_data2", act_tx_data, 8'h30);
        wait_idle("rr_drain");

        $display("[TB] pointer at 3 then wrap to 0");
        push_byte(3, 8'hB3, 1'b1);
        push_byte(1, 8'hA1, 1'b1);
        drive_reqs();
        applyStimulus(1);
        checkOutput("ptr3_grant", act_grant, 4'b1000);
        applyStimulus(2);
        checkOutput("wrap_grant", act_grant, 4'b0010);
        wait_idle("wrap_drain");

        $display("[TB] packet lock");
        push_byte(1, 8'h41, 1'b0);
        push_byte(1, 8'h42, 1'b0);
        push_byte(1, 8'h43, 1'b1);
        drive_reqs();
        applyStimulus(1);
        checkOutput("lock_grant_a", act_grant, 4'b0010);
        push_byte(3, 8'hD3, 1'b1);
        drive_reqs();
        applyStimulus(1);
        checkOutput("lock_grant_b", act_grant, 4'b0010);
        applyStimulus(1);
        checkOutput("lock_grant_c", act_grant, 4'b0010);
        applyStimulus(1);
        checkOutput("lock_bubble", act_grant, 4'b0000);
        applyStimulus(1);
        checkOutput("lock_next", act_grant, 4'b1000);
        wait_idle("lock_drain");

        $display("[TB] backpressure");
        tx_ready = 1'b0;
        push_byte(0, 8'hC1, 1'b0);
        push_byte(0, 8'hC2, 1'b1);
        drive_reqs();
        applyStimulus(1);
        checkOutput("bp_ready_empty", act_req_ready, 4'b0001);
        applyStimulus(1);
        checkOutput("bp_ready_full", act_req_ready, 4'b0000);
        checkOutput("bp_tx_valid", act_tx_valid, 1);
        checkOutput("bp_tx_data", act_tx_data, 8'hC1);
        applyStimulus(19);
        checkOutput("bp_ready_late", act_req_ready, 4'b0000);
        checkOutput("bp_tx_data_late", act_tx_data, 8'hC1);
        checkOutput("bp_grant_late", act_grant, 4'b0001);
        tx_ready = 1'b1;
        #1;
        checkOutput("bp_ready_drain", act_req_ready, 4'b0001);
        wait_idle("bp_drain");

        $display("[TB] reset mid-packet");
        tx_ready = 1'b0;
        src_push(2, 8'hE1, 1'b0);
        src_push(2, 8'hE2, 1'b0);
        src_push(2, 8'hE3, 1'b1);
        drive_reqs();
        applyStimulus(2);
        checkOutput("mid_busy", act_busy, 1);
        reset_n_a = 1'b0;
        applyStimulus(1);
        checkOutput("mid_rst_grant", act_grant, 0);
        checkOutput("mid_rst_ready", act_req_ready, 0);
        checkOutput("mid_rst_tx_valid", act_tx_valid, 0);
        checkOutput("mid_rst_tx_data", act_tx_data, 0);
        checkOutput("mid_rst_busy", act_busy, 0);
        for (int i = 0; i < NR; i++) src_q[i].delete();
        reset_n_a = 1'b1;
        tx_ready  = 1'b1;
        push_byte(0, 8'hF0, 1'b1);
        push_byte(3, 8'hF3, 1'b1);
        drive_reqs();
        applyStimulus(1);
        checkOutput("restart_ptr0", act_grant, 4'b0001);
        wait_idle("restart_drain");

        $display("[TB] burst cap");
        reset_n_a = 1'b0;
        sel       = 1'b1;
        reset_n_b = 1'b0;
        applyStimulus(1);
        checkOutput("b_rst_grant", act_grant, 0);
        checkOutput("b_rst_tx_valid", act_tx_valid, 0);
        reset_n_b = 1'b1;
        for (int k = 1; k <= 5; k++) src_push(0, 8'(k), 1'b0);
        for (int k = 1; k <= 3; k++) src_push(1, 8'(8'h10 + k), 1'b1);
        burst_exp = '{8'h01, 8'h02, 8'h11, 8'h03, 8'h04, 8'h12, 8'h05, 8'h13};
        for (int k = 0; k < 8; k++) exp_q.push_back(burst_exp[k]);
        drive_reqs();
        applyStimulus(3);
        checkOutput("burst_release", act_grant, 4'b0000);
        wait_idle("burst_drain");

        $display("[TB] stall timeout");
        reset_n_b = 1'b0;
        applyStimulus(1);
        reset_n_b = 1'b1;
        push_byte(2, 8'h21, 1'b0);
        drive_reqs();
        applyStimulus(1);
        checkOutput("stall_grant", act_grant, 4'b0100);
        applyStimulus(1);
        push_byte(3, 8'h31, 1'b1);
        drive_reqs();
        checkOutput("stall_start", act_grant, 4'b0100);
        applyStimulus(7);
        checkOutput("stall_hold", act_grant, 4'b0100);
        applyStimulus(1);
        checkOutput("stall_release", act_grant, 4'b0000);
        applyStimulus(1);
        checkOutput("stall_next", act_grant, 4'b1000);
        wait_idle("stall_drain");

        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
